// File: rtl/if_fetch_stage_if.sv
// Instruction memory bus between the fetch stage and a synchronous imem.
// master: fetch side (req/addr out, rdata in); slave: memory side.
interface if_fetch_stage_if #(
  parameter int XLEN = 64
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV64I fetch stage: PC register, imem request, skid buffer, IF/ID register.
// Ports: clk, rst, stall, redirect_valid/pc, imem (master), if_id_valid/pc/instr.
module if_fetch_stage #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  if_fetch_stage_if.master imem,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } skid_t;

  // No compressed ISA: fetch addresses are always word aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            skid_valid_q, skid_valid_d;
  skid_t           skid_q, skid_d;
  if_id_t          if_id_q, if_id_d;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            live;

  always_comb begin
    req  = ~rst & (redirect_valid | ~stall);
    addr = redirect_valid ? (redirect_pc & ALIGN_MASK) : pc_q;
    // A redirect in the response cycle kills the stale word.
    live = inflight_q & ~redirect_valid;

    pc_d          = req ? addr + XLEN'(4) : pc_q;
    inflight_d    = req;
    inflight_pc_d = addr;

    if_id_d      = if_id_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    unique case (1'b1)
      redirect_valid: begin
        if_id_d.valid = 1'b0;
        if_id_d.instr = NOP_INSTR;
        skid_valid_d  = 1'b0;
      end
      ~redirect_valid & stall: begin
        if (live) begin
          skid_d       = '{pc: inflight_pc_q, instr: imem.imem_rdata};
          skid_valid_d = 1'b1;
        end
      end
      ~redirect_valid & ~stall: begin
        unique case (1'b1)
          skid_valid_q: begin
            if_id_d      = '{valid: 1'b1, pc: skid_q.pc,
                             instr: skid_q.instr};
            skid_valid_d = 1'b0;
          end
          ~skid_valid_q & live: begin
            if_id_d = '{valid: 1'b1, pc: inflight_pc_q,
                        instr: imem.imem_rdata};
          end
          ~skid_valid_q & ~live: begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      if_id_q       <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      if_id_q       <= if_id_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: scoreboard of expected PCs
// in program order, plus directed checks on stall/redirect/reset corners.
module tb_if_fetch_stage;
  localparam int XLEN = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  bit mon_en = 1'b0;
  bit upd_last = 1'b0;

  if_fetch_stage_if #(.XLEN(XLEN)) imem ();

  if_fetch_stage #(
    .XLEN(XLEN),
    .RESET_PC('0),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem(imem.master),
    .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return 32'h100 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Synchronous memory: word i holds 0x100+i.
  always @(posedge clk) begin
    if (imem.imem_req) imem.imem_rdata <= word(imem.imem_addr);
    upd_last <= ~stall | redirect_valid;
  end

  // A new IF/ID value exists only if the last edge was not a stall.
  always @(negedge clk) begin
    if (mon_en && upd_last && if_id_valid) begin
      chk("q_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("if_id_pc", if_id_pc, e);
        chk("if_id_instr", 64'(if_id_instr), 64'(word(e)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
  endtask

  task automatic push_seq(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  initial begin
    // 1: reset state, free run, first valid after two cycles
    do_reset();
    settle();
    chk("rst_valid", 64'(if_id_valid), 64'd0);
    chk("rst_pc", if_id_pc, 64'd0);
    chk("rst_instr", 64'(if_id_instr), 64'(NOP));
    chk("rst_req", 64'(imem.imem_req), 64'd0);
    push_seq(64'h0, 8);
    mon_en = 1'b1;
    rst = 1'b0;
    settle();
    chk("c0_req", 64'(imem.imem_req), 64'd1);
    chk("c0_addr", imem.imem_addr, 64'h0);
    tick();
    settle();
    chk("c1_valid", 64'(if_id_valid), 64'd0);
    tick();
    settle();
    chk("c2_valid", 64'(if_id_valid), 64'd1);
    drain();

    // 2: stall three cycles while PC 8 is in flight
    do_reset();
    push_seq(64'h0, 5);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    stall = 1'b1;
    settle();
    chk("stall_req", 64'(imem.imem_req), 64'd0);
    chk("stall_pc0", if_id_pc, 64'h4);
    tick();
    settle();
    chk("stall_pc1", if_id_pc, 64'h4);
    tick();
    settle();
    chk("stall_pc2", if_id_pc, 64'h4);
    tick();
    stall = 1'b0;
    settle();
    chk("pc_once", imem.imem_addr, 64'hC);
    drain();

    // 3: redirect to 0x40 while IF/ID holds PC 8
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    push_seq(64'h40, 3);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    settle();
    chk("rd_hold_pc", if_id_pc, 64'h8);
    chk("rd_addr", imem.imem_addr, 64'h40);
    tick();
    redirect_valid = 1'b0;
    settle();
    chk("rd_bubble_v", 64'(if_id_valid), 64'd0);
    chk("rd_bubble_i", 64'(if_id_instr), 64'(NOP));
    tick();
    settle();
    chk("rd_target", if_id_pc, 64'h40);
    drain();

    // 4: redirect and stall together with the skid full
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    push_seq(64'h80, 3);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    stall = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h80;
    settle();
    chk("rs_req", 64'(imem.imem_req), 64'd1);
    chk("rs_addr", imem.imem_addr, 64'h80);
    tick();
    redirect_valid = 1'b0;
    settle();
    chk("rs_flush", 64'(if_id_valid), 64'd0);
    tick();
    stall = 1'b0;
    tick();
    settle();
    chk("rs_target", if_id_pc, 64'h80);
    drain();

    // 5: misaligned redirect target is forced to word alignment
    do_reset();
    exp_q.push_back(64'h0);
    push_seq(64'h40, 3);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h43;
    settle();
    chk("align_addr", imem.imem_addr, 64'h40);
    tick();
    redirect_valid = 1'b0;
    tick();
    settle();
    chk("align_pc", if_id_pc, 64'h40);
    drain();

    // 6: reset during stall with skid full
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    tick();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    settle();
    chk("mrst_valid", 64'(if_id_valid), 64'd0);
    chk("mrst_req", 64'(imem.imem_req), 64'd0);
    push_seq(64'h0, 4);
    rst = 1'b0;
    stall = 1'b0;
    settle();
    chk("mrst_addr", imem.imem_addr, 64'h0);
    drain();

    // 7: PC increment wraps at the top of the address space
    do_reset();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    settle();
    chk("wrap_addr", imem.imem_addr, 64'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
